// File: rtl/shift4_feeder.sv
// Nibble feeder: buffers upstream nibbles and drives a downstream shift register with one
// load pulse and SHIFTS ena pulses per nibble. Define SHIFT4_FEEDER_FIFO_EN for a 4-entry FIFO.
module shift4_feeder #(
   parameter int SHIFTS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [3:0] in_data,
   output logic       in_ready,
   input  logic       hold,
   output logic       load,
   output logic       ena,
   output logic [3:0] data,
   output logic       busy,
   output logic       done,
   output logic [2:0] level
);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

   state_t     state, state_nx;
   logic [2:0] cnt, cnt_nx;
   logic [3:0] cur, cur_nx;
   logic       push, pop, full;
   logic [3:0] head;

   assign in_ready = !full && !reset;
   assign push     = in_valid && in_ready;

`ifdef SHIFT4_FEEDER_FIFO_EN
   logic [3:0] mem [4];
   logic [1:0] wr_ptr, rd_ptr;
   logic [2:0] count;

   // NOTE: the storage array is not reset; pointers and count alone decide which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= 2'd0;
         rd_ptr <= 2'd0;
         count  <= 3'd0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 2'd1;
         if (pop)  rd_ptr <= rd_ptr + 2'd1;
         if (push && !pop)      count <= count + 3'd1;
         else if (pop && !push) count <= count - 3'd1;
      end
   end

   assign full  = (count == 3'd4);
   assign level = count;
   assign head  = mem[rd_ptr];
`else
   logic [3:0] hold_reg;
   logic       hold_full;

   always_ff @(posedge clk) begin
      if (push) hold_reg <= in_data;
   end

   always_ff @(posedge clk) begin
      if (reset) hold_full <= 1'b0;
      else       hold_full <= push || (hold_full && !pop);
   end

   assign full  = hold_full;
   assign level = {2'b00, hold_full};
   assign head  = hold_reg;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 3'd0;
         cur   <= 4'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         cur   <= cur_nx;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      cur_nx   = cur;
      pop      = 1'b0;
      case (state)
         IDLE: begin
            if (level != 3'd0) begin
               pop      = 1'b1;
               cur_nx   = head;
               state_nx = LOAD;
            end
         end
         LOAD: begin
            state_nx = SHIFT;
            cnt_nx   = 3'(SHIFTS);
         end
         SHIFT: begin
            if (!hold) begin
               if (cnt == 3'd1) begin
                  cnt_nx = 3'd0;
                  // Chain straight into the next nibble when one is waiting.
                  if (level != 3'd0) begin
                     pop      = 1'b1;
                     cur_nx   = head;
                     state_nx = LOAD;
                  end else begin
                     state_nx = IDLE;
                  end
               end else begin
                  cnt_nx = cnt - 3'd1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign load = (state == LOAD);
   assign ena  = (state == SHIFT) && !hold;
   assign done = ena && (cnt == 3'd1);
   assign busy = (state != IDLE);
   assign data = cur;

endmodule

// File: doc/shift4_feeder.md
SHIFT4_FEEDER -- requirements
Module: shift4_feeder

Interface
REQ-001: Parameter SHIFTS, default 4, SHALL set the number of ena pulses issued per loaded nibble; legal range 1..7.
REQ-002: clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003: reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004: in_valid  input  1  SHALL indicate that upstream presents a nibble.
REQ-005: in_data  input  4  SHALL carry the nibble to be loaded.
REQ-006: in_ready  output  1  SHALL indicate the buffer can accept; a transfer occurs on an edge with in_valid && in_ready.
REQ-007: hold  input  1  SHALL stall shifting while high.
REQ-008: load  output  1  SHALL drive the downstream shift register's load.
REQ-009: ena  output  1  SHALL drive the downstream shift register's ena.
REQ-010: data  output  4  SHALL drive the downstream shift register's data.
REQ-011: busy  output  1  SHALL be high whenever state != IDLE.
REQ-012: done  output  1  SHALL pulse high in the cycle carrying the final ena of a nibble.
REQ-013: level  output  3  SHALL report the number of buffered nibbles, excluding the nibble in flight.

Function
REQ-014: The FSM SHALL have states IDLE, LOAD, SHIFT, with a 3-bit shift counter cnt and a 4-bit in-flight register cur.
REQ-015: In IDLE with level>0, the next edge SHALL pop the oldest entry into cur and enter LOAD.
REQ-016: Outputs SHALL be Moore: load=(state==LOAD), data=cur, ena=(state==SHIFT && !hold).
REQ-017: LOAD SHALL last exactly one cycle, then enter SHIFT with cnt=SHIFTS; hold SHALL NOT affect LOAD.
REQ-018: In SHIFT, each edge with !hold SHALL decrement cnt; with hold high, cnt and state SHALL be frozen.
REQ-019: done SHALL equal ena && cnt==1.
REQ-020: On the done edge, the FSM SHALL enter LOAD with a pop if level>0 (no idle gap), else IDLE.
REQ-021: A nibble accepted into an empty buffer while in IDLE SHALL cause load high in the cycle after the next edge (acceptance edge N, pop edge N+1, load high N+1..N+2).
REQ-022: in_ready SHALL equal !full && !reset; a push and pop on the same edge SHALL both take effect, and there SHALL be no input-to-output bypass.
REQ-023: Nibbles SHALL be issued in acceptance order; none SHALL be dropped or duplicated.

Reset
REQ-024: On an edge with reset high, the block SHALL enter IDLE, clearing cur=0, cnt=0, and the buffer (level=0).
REQ-025: After reset, load=0, ena=0, data=0, busy=0, done=0, level=0, and in_ready=1 in the first cycle after reset deasserts.
REQ-026: Reset mid-operation SHALL discard the in-flight nibble and all buffered nibbles, with no further load or ena for them.

Configuration
REQ-027: With SHIFT4_FEEDER_FIFO_EN defined, the buffer SHALL be a 4-entry FIFO (level 0..4; full at 4).
REQ-028: Without SHIFT4_FEEDER_FIFO_EN, the buffer SHALL be a single holding register (level 0..1; full at 1); all other behaviour is identical.

Verification
REQ-029: SHIFTS=4, idle; push A at edge N -> load=1, data=A in cycle N+1; ena=1 for cycles N+2..N+5; done=1 in cycle N+5 only; busy=0 from N+6.
REQ-030: Push A, then 5 back-to-back -> 4 ena for A, with load data=5 in the cycle immediately after A's done; data sequence A,5 with no idle cycle.
REQ-031: Hold high for 3 cycles starting at the 2nd ena cycle -> ena=0 for those 3 cycles, cnt frozen; LOAD-to-done spans 1+4+3 cycles; total ena pulses=4.
REQ-032: Hold high, stream 6 nibbles 1..6 -> with macro, 5 accepted (1 in cur, level=4), in_ready=0, and nibble 6 stalls until a pop; without macro, 2 accepted (level=1).
REQ-033: Reset high for one cycle during the 2nd ena of nibble C with level=2 -> next cycle load=ena=busy=done=0, level=0; in_ready=0 during reset and 1 after; no later load of buffered data.
